execute_stage: RTL and testbench

Execute stage of the Riscv151 three-stage pipeline (fetch, decode-read, execute/writeback). Consumes the registered control and operands from the decode-read stage. It does the following:
- forwards writeback results into the operands and runs the ALU;
- resolves branches and jumps, driving the PC redirect and the bubble back to fetch/decode;
- issues dcache requests;
- holds the writeback pipeline register, load extraction, the tohost CSR and a retired-instruction counter.

Its writeback outputs feed the decode-read stage's register-file write port.

---
 rtl/execute_stage.sv | 156 +++++++++++++++
 tb/tb_execute_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: Riscv151 execute/writeback stage (forwarding, ALU, branch resolve, dcache request, WB register, tohost csr, instret)
// In : clk, reset, stall, valid, pc, ra, rb, imm, rs1, rs2, rd, alu_op, funct3, a_sel, b_sel, is_jump, jump_conditional,
//      reg_we, mem_we, mem_rr, csr_write, csr_imm, dcache_dout
// Out: pc_select, jump_target, bubble, dcache_addr/we/re/din, wb_we, wb_rd, wb_data, csr, instret
module execute_stage #(
  parameter logic [31:0] RESET_CSR      = 32'h0,
  parameter bit          ENABLE_INSTRET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        valid,
  input  logic [31:0] pc,
  input  logic [31:0] ra,
  input  logic [31:0] rb,
  input  logic [31:0] imm,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic        a_sel,
  input  logic        b_sel,
  input  logic        is_jump,
  input  logic        jump_conditional,
  input  logic        reg_we,
  input  logic        mem_we,
  input  logic        mem_rr,
  input  logic        csr_write,
  input  logic        csr_imm,
  input  logic [31:0] dcache_dout,
  output logic        pc_select,
  output logic [31:0] jump_target,
  output logic        bubble,
  output logic [31:0] dcache_addr,
  output logic [3:0]  dcache_we,
  output logic        dcache_re,
  output logic [31:0] dcache_din,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] csr,
  output logic [31:0] instret
);
  logic v_reg_we, v_mem_we, v_mem_rr, v_csr_write, v_is_jump, cond;
  logic [31:0] fa, fb, a, b, alu, sh, ld, csr_d, instret_d;
  logic        we_q, jump_q, rr_q, csri_q;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] alu_q, pc4_q, ocsr_q, csr_q, instret_q;

  assign v_reg_we    = reg_we & valid;
  assign v_mem_we    = mem_we & valid;
  assign v_mem_rr    = mem_rr & valid;
  assign v_csr_write = csr_write & valid;
  assign v_is_jump   = is_jump & valid;

  // x0 is never forwarded; the WB value is the newest copy of rs1/rs2
  assign fa = (wb_we && wb_rd != 5'd0 && wb_rd == rs1) ? wb_data : ra;
  assign fb = (wb_we && wb_rd != 5'd0 && wb_rd == rs2) ? wb_data : rb;
  assign a  = a_sel ? pc : fa;
  assign b  = b_sel ? imm : fb;

  always_comb begin
    alu = a + b;
    case (alu_op)
      4'd1:  alu = a - b;
      4'd2:  alu = a << b[4:0];
      4'd3:  alu = {31'b0, $signed(a) < $signed(b)};
      4'd4:  alu = {31'b0, a < b};
      4'd5:  alu = a ^ b;
      4'd6:  alu = a >> b[4:0];
      4'd7:  alu = $unsigned($signed(a) >>> b[4:0]);
      4'd8:  alu = a | b;
      4'd9:  alu = a & b;
      4'd10: alu = b;
      default: alu = a + b;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000: cond = fa == fb;
      3'b001: cond = fa != fb;
      3'b100: cond = $signed(fa) < $signed(fb);
      3'b101: cond = $signed(fa) >= $signed(fb);
      3'b110: cond = fa < fb;
      3'b111: cond = fa >= fb;
      default: cond = 1'b0;
    endcase
  end

  assign pc_select   = v_is_jump & (!jump_conditional | cond) & !stall;
  assign bubble      = pc_select;
  assign jump_target = {alu[31:1], 1'b0};
  assign dcache_addr = alu;
  assign dcache_re   = v_mem_rr;
  assign dcache_din  = funct3 == 3'b000 ? {4{fb[7:0]}} : funct3 == 3'b001 ? {2{fb[15:0]}} : fb;

  // misaligned halfword/word stores are dropped rather than split
  always_comb begin
    dcache_we = 4'b0000;
    if (v_mem_we)
      dcache_we = funct3 == 3'b000 ? 4'b0001 << alu[1:0] :
                  funct3 == 3'b001 ? (alu[0] ? 4'b0000 : alu[1] ? 4'b1100 : 4'b0011) :
                  funct3 == 3'b010 ? (alu[1:0] == 2'b00 ? 4'b1111 : 4'b0000) : 4'b0000;
  end

  // load data arrives in the WB cycle; lane chosen by the latched address
  assign sh = dcache_dout >> {lane_q, 3'b000};
  assign ld = f3_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
              f3_q == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
              f3_q == 3'b100 ? {24'b0, sh[7:0]} :
              f3_q == 3'b101 ? {16'b0, sh[15:0]} : dcache_dout;

  assign wb_we   = we_q;
  assign wb_rd   = rd_q;
  assign wb_data = rr_q ? ld : jump_q ? pc4_q : csri_q ? ocsr_q : alu_q;
  assign csr     = csr_q;
  assign instret = instret_q;

  assign csr_d     = v_csr_write ? (csr_imm ? {27'b0, imm[4:0]} : fa) : csr_q;
  assign instret_d = instret_q + 32'(valid & ENABLE_INSTRET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q      <= 1'b0;
      rd_q      <= 5'd0;
      alu_q     <= 32'd0;
      pc4_q     <= 32'd0;
      jump_q    <= 1'b0;
      rr_q      <= 1'b0;
      csri_q    <= 1'b0;
      f3_q      <= 3'd0;
      lane_q    <= 2'd0;
      ocsr_q    <= 32'd0;
      csr_q     <= RESET_CSR;
      instret_q <= 32'd0;
    end else if (!stall) begin
      we_q      <= v_reg_we;
      rd_q      <= rd;
      alu_q     <= alu;
      pc4_q     <= pc + 32'd4;
      jump_q    <= v_is_jump;
      rr_q      <= v_mem_rr;
      csri_q    <= v_csr_write;
      f3_q      <= funct3;
      lane_q    <= alu[1:0];
      ocsr_q    <= csr_q;
      csr_q     <= csr_d;
      instret_q <= instret_d;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed self-checking bench for execute_stage
module tb_execute_stage;
  logic clk = 1'b0, reset, stall, valid;
  logic [31:0] pc, ra, rb, imm, dcache_dout;
  logic [4:0] rs1, rs2, rd;
  logic [3:0] alu_op;
  logic [2:0] funct3;
  logic a_sel, b_sel, is_jump, jump_conditional, reg_we, mem_we, mem_rr, csr_write, csr_imm;
  logic pc_select, bubble, dcache_re, wb_we;
  logic [31:0] jump_target, dcache_addr, dcache_din, wb_data, csr, instret;
  logic [3:0] dcache_we;
  logic [4:0] wb_rd;
  logic [31:0] exp_ir, ir0;
  int checks = 0, errors = 0;

  execute_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .valid(valid), .pc(pc), .ra(ra), .rb(rb), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op), .funct3(funct3), .a_sel(a_sel), .b_sel(b_sel),
    .is_jump(is_jump), .jump_conditional(jump_conditional), .reg_we(reg_we), .mem_we(mem_we),
    .mem_rr(mem_rr), .csr_write(csr_write), .csr_imm(csr_imm), .dcache_dout(dcache_dout),
    .pc_select(pc_select), .jump_target(jump_target), .bubble(bubble), .dcache_addr(dcache_addr),
    .dcache_we(dcache_we), .dcache_re(dcache_re), .dcache_din(dcache_din), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .csr(csr), .instret(instret)
  );

  always #5 clk = ~clk;

  // retired-instruction reference: one per valid, unstalled edge
  always @(posedge clk or posedge reset)
    if (reset) exp_ir = 32'd0;
    else if (valid && !stall) exp_ir = exp_ir + 32'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    stall = 0; valid = 0; pc = 0; ra = 0; rb = 0; imm = 0; rs1 = 0; rs2 = 0; rd = 0;
    alu_op = 0; funct3 = 0; a_sel = 0; b_sel = 0; is_jump = 0; jump_conditional = 0;
    reg_we = 0; mem_we = 0; mem_rr = 0; csr_write = 0; csr_imm = 0; dcache_dout = 0;
  endtask

  task automatic alu_vec(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input string tag);
    clr; valid = 1; reg_we = 1; rd = 10; alu_op = op; ra = x; rb = y;
    tick;
    chk(tag, wb_data, exp);
  endtask

  initial begin
    clr; reset = 1;
    tick; tick;
    chk("rst_wb_we", {31'b0, wb_we}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_csr", csr, 0);
    chk("rst_instret", instret, 0);
    reset = 0;
    tick;
    // forwarding: ADDI x1,x0,5 ; ADD x2,x1,x1 with stale ra/rb
    clr; valid = 1; reg_we = 1; rd = 1; b_sel = 1; imm = 5;
    tick;
    chk("addi_wb", wb_data, 5);
    clr; valid = 1; reg_we = 1; rd = 2; rs1 = 1; rs2 = 1;
    #1 chk("fwd_addr", dcache_addr, 10);
    tick;
    chk("fwd_wb", wb_data, 10);
    chk("fwd_rd", {27'b0, wb_rd}, 2);
    chk("fwd_we", {31'b0, wb_we}, 1);
    // ALU ops (rs1=rs2=0, no forwarding)
    alu_vec(4'd1, 5, 7, 32'hFFFFFFFE, "sub");
    alu_vec(4'd2, 1, 32'h3F, 32'h80000000, "sll");
    alu_vec(4'd3, 32'hFFFFFFFF, 1, 1, "slt");
    alu_vec(4'd4, 32'hFFFFFFFF, 1, 0, "sltu");
    alu_vec(4'd5, 32'hF0F0, 32'hFF00, 32'h0FF0, "xor");
    alu_vec(4'd6, 32'h80000000, 4, 32'h08000000, "srl");
    alu_vec(4'd7, 32'h80000000, 4, 32'hF8000000, "sra");
    alu_vec(4'd8, 32'hF0, 32'h0F, 32'hFF, "or");
    alu_vec(4'd9, 32'hF0, 32'h3C, 32'h30, "and");
    alu_vec(4'd10, 32'h11, 32'h55, 32'h55, "passb");
    alu_vec(4'd15, 2, 3, 5, "op15_add");
    // branch BEQ
    clr; valid = 1; is_jump = 1; jump_conditional = 1; funct3 = 0; ra = 7; rb = 7; rs1 = 3; rs2 = 4;
    a_sel = 1; b_sel = 1; pc = 32'h100; imm = 32'h20;
    #1 chk("beq_sel", {31'b0, pc_select}, 1);
    chk("beq_bub", {31'b0, bubble}, 1);
    chk("beq_tgt", jump_target, 32'h120);
    rb = 8;
    #1 chk("beq_nt", {31'b0, pc_select}, 0);
    funct3 = 3'b001;
    #1 chk("bne_t", {31'b0, pc_select}, 1);
    stall = 1;
    #1 chk("bne_stall", {31'b0, bubble}, 0);
    stall = 0; valid = 0;
    #1 chk("bne_invalid", {31'b0, pc_select}, 0);
    // stores
    clr; valid = 1; mem_we = 1; funct3 = 0; ra = 32'h1000; rs1 = 5; imm = 3; b_sel = 1; rb = 32'hAB; rs2 = 6;
    #1 chk("sb_we", {28'b0, dcache_we}, 4'b1000);
    chk("sb_din", dcache_din, 32'hABABABAB);
    chk("sb_addr", dcache_addr, 32'h1003);
    funct3 = 1; imm = 1;
    #1 chk("sh_mis", {28'b0, dcache_we}, 0);
    imm = 2; rb = 32'h1234;
    #1 chk("sh_hi", {28'b0, dcache_we}, 4'b1100);
    chk("sh_din", dcache_din, 32'h12341234);
    funct3 = 2; imm = 0;
    #1 chk("sw_we", {28'b0, dcache_we}, 4'b1111);
    valid = 0;
    #1 chk("sw_invalid", {28'b0, dcache_we}, 0);
    // loads
    clr; valid = 1; mem_rr = 1; reg_we = 1; rd = 7; funct3 = 0; imm = 2; b_sel = 1;
    #1 chk("lb_re", {31'b0, dcache_re}, 1);
    tick;
    clr; dcache_dout = 32'h00800000;
    #1 chk("lb_wb", wb_data, 32'hFFFFFF80);
    chk("lb_rd", {27'b0, wb_rd}, 7);
    clr; valid = 1; mem_rr = 1; reg_we = 1; rd = 7; funct3 = 3'b100; imm = 2; b_sel = 1;
    tick;
    clr; dcache_dout = 32'h00800000;
    #1 chk("lbu_wb", wb_data, 32'h00000080);
    chk("lb_noreq", {31'b0, dcache_re}, 0);
    // CSRWI uimm=1 under a 3-cycle stall
    clr; valid = 1; csr_write = 1; csr_imm = 1; imm = 1; stall = 1;
    ir0 = exp_ir;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_csr", csr, 0);
      chk("stall_ir", instret, ir0);
    end
    stall = 0;
    tick;
    chk("csrwi", csr, 1);
    chk("csrwi_ir", instret, ir0 + 1);
    // CSRW from rs1 with rd capturing old csr
    clr; valid = 1; csr_write = 1; reg_we = 1; rd = 3; rs1 = 9; ra = 32'h12345678;
    tick;
    chk("csrw", csr, 32'h12345678);
    chk("csr_old", wb_data, 1);
    chk("ir_model", instret, exp_ir);
    // JAL then asynchronous reset mid-cycle
    clr; valid = 1; is_jump = 1; reg_we = 1; rd = 1; a_sel = 1; b_sel = 1; pc = 32'h200; imm = 8;
    #1 chk("jal_sel", {31'b0, pc_select}, 1);
    tick;
    chk("jal_wb", wb_data, 32'h204);
    chk("jal_tgt", jump_target, 32'h208);
    #2 reset = 1;
    #1 chk("arst_we", {31'b0, wb_we}, 0);
    chk("arst_data", wb_data, 0);
    chk("arst_csr", csr, 0);
    chk("arst_ir", instret, 0);
    clr;
    tick;
    reset = 0;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
